serial_sub: RTL

- Bit-serial N-bit subtractor computing D = A - B, one bit per clock, LSB first.
- It is the inverse-direction companion of the combinational ripple adder.
- Reuses the existing 1-bit full adder cell (fa_1b) with B inverted and an initial carry-in of 1, i.e. two's-complement subtraction.
- Sits in the arithmetic datapath where area matters more than latency; uses a start/busy/done handshake.

---
 rtl/arith_pkg.sv | 18 +
 rtl/fa_1b.sv | 13 +
 rtl/serial_sub.sv | 134 +++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: serial FSM encoding and a counter width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Smallest r with 2**r >= v; callers keep v >= 2.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fa_1b.sv
// One-bit full adder cell shared by the ripple and serial arithmetic blocks.
module fa_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor (D = A - B, LSB first) built on fa_1b with start/busy/done.
// Optional SERIAL_SUB_FLAGS_EN adds registered zero (Z) and negative (N) result flags.
module serial_sub
  import arith_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] D,
  output logic         Bout,
`ifdef SERIAL_SUB_FLAGS_EN
  output logic         Z,
  output logic         N,
`endif
  output logic         OVF
);

  localparam int unsigned CntW = clog2(W);
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);
  localparam logic [CntW-1:0] CntMsb  = CntW'(W - 2);

  state_e          state_q;
  logic [W-1:0]    a_sr_q, b_sr_q, res_sr_q;
  logic            c_q, c_msb_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q, done_q, bout_q, ovf_q;
  logic [W-1:0]    d_q;
`ifdef SERIAL_SUB_FLAGS_EN
  logic            any_q, z_q, n_q;
`endif

  logic b_inv, fa_s, fa_cout;

  assign b_inv = ~b_sr_q[0];

  // Subtraction as A + ~B + 1: the carry flop is preset to 1 on start.
  fa_1b u_fa (
    .a    (a_sr_q[0]),
    .b    (b_inv),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      c_q      <= 1'b0;
      c_msb_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      any_q    <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            a_sr_q   <= A;
            b_sr_q   <= B;
            res_sr_q <= '0;
            c_q      <= 1'b1;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_SHIFT;
`ifdef SERIAL_SUB_FLAGS_EN
            any_q    <= 1'b0;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          res_sr_q <= {fa_s, res_sr_q[W-1:1]};
          a_sr_q   <= {1'b0, a_sr_q[W-1:1]};
          b_sr_q   <= {1'b0, b_sr_q[W-1:1]};
          c_q      <= fa_cout;
`ifdef SERIAL_SUB_FLAGS_EN
          any_q    <= any_q | fa_s;
`endif
          if (cnt_q == CntMsb) c_msb_q <= fa_cout;
          if (cnt_q == CntLast) begin
            // Result lands on the DONE entry edge, so it is valid while done is high.
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            d_q     <= {fa_s, res_sr_q[W-1:1]};
            bout_q  <= ~fa_cout;
            ovf_q   <= c_msb_q ^ fa_cout;
`ifdef SERIAL_SUB_FLAGS_EN
            z_q     <= ~(any_q | fa_s);
            n_q     <= fa_s;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_q;
  assign Bout = bout_q;
  assign OVF  = ovf_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign Z    = z_q;
  assign N    = n_q;
`endif

endmodule
